// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI3 master.
// Optional macro BRIDGE_RAW_ADDR_CHECK_EN: only same-word data reads wait for a busy write.
module sram_axi_bridge (
    input  logic        clk,
    input  logic        resetn,
    // instruction fetch port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    // data load/store port
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    // AXI read address / data
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address / data / response
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    typedef enum logic       {R_IDLE, R_AR}          rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_t;

    rstate_t     r_rstate, w_rstate_next;
    wstate_t     r_wstate, w_wstate_next;
    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [1:0]  r_arsize;
    logic        r_inst_out, r_data_out;
    logic [31:0] r_awaddr, r_wdata;
    logic [1:0]  r_awsize;
    logic [3:0]  r_wstrb;
    logic        r_awvalid, r_wvalid;

    logic w_raw_block, w_data_rd_cand, w_inst_rd_cand, w_ar_hs;
    logic w_wr_accept, w_aw_done, w_w_done, w_wr_addr_ok;
    logic w_unused;

`ifdef BRIDGE_RAW_ADDR_CHECK_EN
    assign w_raw_block = (r_wstate != W_IDLE) && (data_sram_addr[31:2] == r_awaddr[31:2]);
`else
    assign w_raw_block = (r_wstate != W_IDLE);
`endif

    assign w_data_rd_cand = data_sram_req && !data_sram_wr && !r_data_out && !w_raw_block;
    assign w_inst_rd_cand = inst_sram_req && !r_inst_out;
    assign w_ar_hs        = (r_rstate == R_AR) && arready;

    // NOTE: always_comb gives every output a default first, so no path can infer a latch.
    always_comb begin
        w_rstate_next = r_rstate;
        if (r_rstate == R_IDLE) begin
            if (w_data_rd_cand || w_inst_rd_cand) w_rstate_next = R_AR;
        end else if (arready) begin
            w_rstate_next = R_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rstate   <= R_IDLE;
            r_arid     <= ID_INST;
            r_araddr   <= 32'd0;
            r_arsize   <= 2'd0;
            r_inst_out <= 1'b0;
            r_data_out <= 1'b0;
        end else begin
            r_rstate <= w_rstate_next;
            if (r_rstate == R_IDLE) begin
                if (w_data_rd_cand) begin
                    r_arid   <= ID_DATA;
                    r_araddr <= data_sram_addr;
                    r_arsize <= data_sram_size;
                end else if (w_inst_rd_cand) begin
                    r_arid   <= ID_INST;
                    r_araddr <= inst_sram_addr;
                    r_arsize <= inst_sram_size;
                end
            end
            // A handshake wins over a same-cycle stale response carrying the same ID.
            if (w_ar_hs && r_arid == ID_INST)   r_inst_out <= 1'b1;
            else if (rvalid && rid == ID_INST)  r_inst_out <= 1'b0;
            if (w_ar_hs && r_arid == ID_DATA)   r_data_out <= 1'b1;
            else if (rvalid && rid == ID_DATA)  r_data_out <= 1'b0;
        end
    end

    assign w_wr_accept  = (r_wstate == W_IDLE) && data_sram_req && data_sram_wr;
    assign w_aw_done    = !r_awvalid || awready;
    assign w_w_done     = !r_wvalid  || wready;
    assign w_wr_addr_ok = (r_wstate == W_REQ) && w_aw_done && w_w_done;

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_wr_accept)  w_wstate_next = W_REQ;
            W_REQ:   if (w_wr_addr_ok) w_wstate_next = W_RESP;
            W_RESP:  if (bvalid)       w_wstate_next = W_IDLE;
            default:                   w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= 32'd0;
            r_awsize  <= 2'd0;
            r_wstrb   <= 4'd0;
            r_wdata   <= 32'd0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else begin
            r_wstate <= w_wstate_next;
            if (w_wr_accept) begin
                r_awaddr  <= data_sram_addr;
                r_awsize  <= data_sram_size;
                r_wstrb   <= data_sram_wstrb;
                r_wdata   <= data_sram_wdata;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
            end else if (r_wstate == W_REQ) begin
                if (awready) r_awvalid <= 1'b0;
                if (wready)  r_wvalid  <= 1'b0;
            end
        end
    end

    assign inst_sram_addr_ok = w_ar_hs && (r_arid == ID_INST);
    assign inst_sram_data_ok = rvalid && (rid == ID_INST) && r_inst_out;
    assign inst_sram_rdata   = rdata;
    assign data_sram_addr_ok = (w_ar_hs && (r_arid == ID_DATA)) || w_wr_addr_ok;
    assign data_sram_data_ok = (rvalid && (rid == ID_DATA) && r_data_out)
                             || ((r_wstate == W_RESP) && bvalid);
    assign data_sram_rdata   = rdata;

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, r_arsize};
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (r_rstate == R_AR);
    assign rready  = 1'b1;

    assign awid    = ID_DATA;
    assign awaddr  = r_awaddr;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, r_awsize};
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = r_awvalid;
    assign wid     = ID_DATA;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign wvalid  = r_wvalid;
    assign bready  = 1'b1;

    assign w_unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the core's two SRAM-like request interfaces (instruction fetch, data load/store) into one AXI3 master port. It sits between the core's top level and the AXI interconnect and arbitrates the single AR channel between the two requesters. It sequences write address, write data and write response, and enforces read-after-write ordering on the data side. At most one read per requester and one write may be outstanding at a time.

## Interface
- ID_INST, 4'd0, ARID used for instruction reads
- ID_DATA, 4'd1, ARID/AWID used for data accesses
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_sram_req/wr  in  1 each  fetch request; wr is ignored (fetch is read-only)
- inst_sram_size  in  2  log2 bytes; inst_sram_addr in 32; inst_sram_wstrb/wdata are ignored
- inst_sram_addr_ok  out  1  request accepted (AR handshake this cycle)
- inst_sram_data_ok  out  1  read data valid; inst_sram_rdata out 32
- data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  load/store request
- data_sram_addr_ok/data_ok  out  1 each; data_sram_rdata out 32
- arid/araddr/arsize/arvalid  out  4/32/3/1; arready in 1
- arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0  out  constant
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready  out 1
- awid/awaddr/awsize/awvalid  out  4/32/3/1; awready in 1; awlen/awburst/awlock/awcache/awprot use the same constants as AR
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready in 1
- bid/bresp/bvalid  in  4/2/1; bready  out 1

## Operation
- Read FSM, states R_IDLE → R_AR → R_IDLE. In R_IDLE, pick a candidate and latch its addr, size and ID. Next cycle arvalid=1. Hold it with stable fields until arready. Then return to R_IDLE.
- Read arbitration: a data read (req&~wr) beats an instruction read. A requester is not a candidate while it has a read outstanding. A blocked data read (see RAW rule) does not block an instruction read.
- Per-requester outstanding flag:
  - set on AR handshake;
  - cleared on rvalid with matching rid (rready is constant 1).
- Response routing: data_ok pulses for one cycle on the requester selected by rid. rdata passes straight through combinationally. rresp and rlast are ignored.
- Write FSM, states W_IDLE → W_REQ → W_RESP → W_IDLE.
  - W_IDLE: accept data req&wr. Latch addr, size, wstrb and wdata; assert awvalid and wvalid.
  - W_REQ: drop each valid independently on its own handshake. addr_ok pulses in the cycle the second of the two handshakes completes.
  - W_RESP: bready=1. data_ok pulses on bvalid, then return to W_IDLE.
- RAW rule: a data read is not issued while the write FSM is not in W_IDLE. The address-matching refinement is described under Configuration.
- Size mapping: arsize = awsize = {1'b0,size}. wlast is constant 1. awid = wid = ID_DATA.
- A data read and a data write are never simultaneously candidates: there is one data_sram_req.

## Timing
- Reset values (async assert): arvalid=awvalid=wvalid=0, all addr_ok/data_ok=0, araddr=awaddr=0, FSMs in idle, outstanding flags 0. rready=bready=1 at all times.
- Minimum read latency:
  - req at cycle N;
  - arvalid at N+1;
  - addr_ok at N+1 if arready is already high;
  - data_ok on the rvalid cycle, earliest N+2.
- Minimum write latency:
  - awvalid/wvalid at N+1;
  - addr_ok at N+1 if awready and wready are both high;
  - data_ok on the bvalid cycle.
- addr_ok is combinational from arready/awready/wready and is never asserted without the matching handshake.
- rvalid or bvalid with no matching outstanding transaction (for example after a mid-operation reset) is consumed with no data_ok.
- data_ok for one transaction and addr_ok for the next may assert in the same cycle.
- Reset mid-transaction returns to idle immediately. Valids drop asynchronously.

## Configuration
- BRIDGE_RAW_ADDR_CHECK_EN:
  - Defined: a data read is blocked only while the write FSM is busy and read addr[31:2] == latched write addr[31:2]. Reads to other words proceed during the write.
  - Undefined: any busy write blocks all data reads.

## Test plan
- Single fetch: inst req addr 0x1C000000, size 2, arready=1, rvalid/rid=0/rdata=0x02800C0C two cycles later → addr_ok at N+1, inst data_ok with rdata 0x02800C0C, araddr=0x1C000000, arsize=3'd2.
- Contention: inst and data reads in the same cycle → first AR has arid=1 (data), second has arid=0. Reversed-order R responses are routed to the correct data_ok.
- Store: data req wr=1 addr 0x1C008000 wstrb 4'b0011 wdata 0xDEADBEEF. awready one cycle late, wready immediate → addr_ok when awready arrives, data_ok on bvalid, wlast=1.
- RAW, same word: store to 0x100, then load from 0x100 before bvalid → no arvalid until the cycle after bvalid, in both macro settings.
- RAW, other word: same sequence but load from 0x200 → arvalid before bvalid only with BRIDGE_RAW_ADDR_CHECK_EN defined.
- Reset mid-read: deassert resetn while arvalid=1 → arvalid drops immediately. A stale rvalid after reset produces no data_ok.
